stage_mem: RTL
==============

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 valid_i  in  1  an instruction from the execute stage is present on the *_i inputs.
REQ-004 flush  in  1  synchronous pipeline flush.
REQ-005 mem_op_i  in  4  memory op: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-006 reg_wdata_i  in  32  ALU result; this is the byte address for memory ops and the writeback value otherwise.
REQ-007 mem_wdata_i  in  32  store data (rs2).
REQ-008 reg_waddr_i  in  5  destination register.
REQ-009 we_i  in  1  register write enable.
REQ-010 stall_o  out  1  upstream SHALL hold all *_i inputs while high.
REQ-011 reg_waddr_o  out  5  registered destination register to writeback.
REQ-012 we_o  out  1  registered write enable; 0 means bubble.
REQ-013 reg_wdata_o  out  32  registered writeback data.
REQ-014 misalign_o  out  1  one-cycle misaligned-access flag (config-dependent).
REQ-015 mem_req  out  1  bus request; held high until ack.
REQ-016 mem_we  out  1  1 = write.
REQ-017 mem_addr_o  out  32  word address, with bits [1:0] = 00.
REQ-018 mem_wmask  out  4  byte-lane write strobes; bit0 = byte0, little-endian.
REQ-019 mem_wdata_o  out  32  lane-replicated store data.
REQ-020 mem_rdata  in  32  read data, valid in the ack cycle.
REQ-021 mem_ack  in  1  transaction complete; may be asserted in the first mem_req cycle.

Function
REQ-022 FSM SHALL have exactly two states: IDLE and BUSY.
REQ-023 stall_o SHALL be 1 only in BUSY; inputs are sampled only in IDLE.
REQ-024 IDLE, valid_i=1, non-memory op, no flush -> next edge: outputs = inputs (latency 1), state stays IDLE.
REQ-025 IDLE, valid_i=1, memory op, no flush -> next edge: enter BUSY and latch op, address, store data, waddr and we; mem_req=1; we_o=0.
REQ-026 In BUSY, mem_req, mem_we, mem_addr_o, mem_wmask and mem_wdata_o SHALL stay constant until mem_ack is sampled at 1.
REQ-027 BUSY with mem_ack=1 -> next edge: IDLE, mem_req=0, result presented on the outputs for one cycle; minimum memory-op latency is 2 cycles.
REQ-028 Loads SHALL select the byte lane by addr[1:0] and the half lane by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
REQ-029 Stores: SB data {4{d[7:0]}}, wmask 0001<<addr[1:0]; SH data {2{d[15:0]}}, wmask 0011<<{addr[1],0}; SW data d, wmask 1111.
REQ-030 Stores SHALL force we_o=0; loads pass the latched we.
REQ-031 valid_i=0 or flush=1 in IDLE -> next edge: we_o=0, no bus activity.
REQ-032 flush in BUSY SHALL NOT drop mem_req, and the bus transaction SHALL complete.
REQ-033 A flush seen during BUSY SHALL be remembered, and the completing result SHALL be emitted with we_o=0.
REQ-034 Back-to-back memory ops: the input held during BUSY SHALL be accepted in the first IDLE cycle after ack, with no bubble.

Reset
REQ-035 rst=1 at an edge -> IDLE; mem_req, mem_we, mem_wmask, we_o and misalign_o = 0; reg_waddr_o, reg_wdata_o, mem_addr_o and mem_wdata_o = 0.
REQ-036 rst during BUSY SHALL abandon the transaction: mem_req=0 next cycle, and a late mem_ack SHALL be ignored in IDLE.

Configuration
REQ-037 Macro MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL stay IDLE, issue no mem_req, and next edge give misalign_o=1 and we_o=0.
REQ-038 Macro absent: misalign_o is tied 0; misaligned ops proceed as in REQ-028/029, which ignores addr[0] for halves and addr[1:0] for words.

Verification
REQ-039 Execute ADD result 0x1234, waddr 5, we=1 -> next cycle we_o=1, reg_waddr_o=5, reg_wdata_o=0x1234, no mem_req.
REQ-040 LB at 0x103, mem_rdata=0x80FFFFFF, ack on the first req cycle -> 2 cycles later reg_wdata_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-041 SH at 0x202, data 0xABCD1234, ack after 3 wait cycles -> mem_addr_o=0x200, wmask=1100, wdata=0x12341234, stall_o high for 4 cycles, we_o=0.
REQ-042 LW at 0x10 with flush during BUSY -> mem_req held until ack, completing cycle has we_o=0.
REQ-043 rst during BUSY, then mem_ack=1 one cycle later -> mem_req=0, state IDLE, we_o stays 0.
REQ-044 With MEM_ALIGN_CHECK_EN, LW at 0x6 -> no mem_req, next cycle misalign_o=1, we_o=0; without the macro, mem_addr_o=0x4.

Source files
------------

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem -- memory-access pipeline stage.
//
// Takes one instruction per cycle from execute. Non-memory instructions pass
// straight to writeback with one cycle of latency. Loads and stores enter a
// two-state FSM (IDLE/BUSY) that keeps the bus request stable until mem_ack
// and stalls upstream in the meantime. Load data is lane-selected and
// sign/zero-extended. Store data is lane-replicated and gets byte strobes.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses (no bus request, one-cycle misalign_o pulse). If it is not defined,
// misalign_o is held at 0 and misaligned addresses are simply truncated onto
// their natural lanes.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   valid_i, flush       instruction present / pipeline flush
//   mem_op_i             0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW
//   reg_wdata_i          ALU result (byte address for memory ops)
//   mem_wdata_i          store data (rs2)
//   reg_waddr_i, we_i    destination register / write enable
//   stall_o              high while BUSY; upstream holds its inputs
//   reg_waddr_o, we_o,
//   reg_wdata_o          registered writeback outputs
//   misalign_o           one-cycle misaligned-access flag
//   mem_req, mem_we,
//   mem_addr_o,
//   mem_wmask,
//   mem_wdata_o          bus request (word address, strobes, data)
//   mem_rdata, mem_ack   bus response (rdata valid in the ack cycle)
// -----------------------------------------------------------------------------
module stage_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        we_i,
  output logic        stall_o,
  output logic [4:0]  reg_waddr_o,
  output logic        we_o,
  output logic [31:0] reg_wdata_o,
  output logic        misalign_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  // State and latched operation
  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;          // addr[1:0] of the pending access
  logic        ld_we_q, ld_we_d;
  logic [4:0]  ld_waddr_q, ld_waddr_d;
  logic        flush_q, flush_d;    // flush seen while BUSY

  // Next values of the registered outputs
  logic [4:0]  reg_waddr_nxt;
  logic        we_nxt;
  logic [31:0] reg_wdata_nxt;
  logic        misalign_nxt;
  logic        mem_req_nxt;
  logic        mem_we_nxt;
  logic [31:0] mem_addr_nxt;
  logic [3:0]  mem_wmask_nxt;
  logic [31:0] mem_wdata_nxt;

  // Input decode
  logic        is_load_i, is_store_i, misaligned_i;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        is_load_q;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign stall_o = (state_q == BUSY);

  assign is_load_i  = (mem_op_i == OP_LB)  || (mem_op_i == OP_LH)  ||
                      (mem_op_i == OP_LW)  || (mem_op_i == OP_LBU) ||
                      (mem_op_i == OP_LHU);
  assign is_store_i = (mem_op_i == OP_SB)  || (mem_op_i == OP_SH)  ||
                      (mem_op_i == OP_SW);
  assign is_load_q  = (op_q == OP_LB)  || (op_q == OP_LH)  || (op_q == OP_LW) ||
                      (op_q == OP_LBU) || (op_q == OP_LHU);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_i =
      (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) &&
       reg_wdata_i[0]) ||
      (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (reg_wdata_i[1:0] != 2'b00));
`else
  assign misaligned_i = 1'b0;
`endif

  // Store formatting: replicate data across lanes so the strobes alone pick
  // the target bytes, whatever the low address bits are.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    st_data = 32'h0;
    st_mask = 4'b0000;
    case (mem_op_i)
      OP_SB: begin
        st_data = {4{mem_wdata_i[7:0]}};
        st_mask = 4'b0001 << reg_wdata_i[1:0];
      end
      OP_SH: begin
        st_data = {2{mem_wdata_i[15:0]}};
        st_mask = 4'b0011 << {reg_wdata_i[1], 1'b0};
      end
      OP_SW: begin
        st_data = mem_wdata_i;
        st_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load lane selection and extension, using the latched low address bits
  always_comb begin
    ld_byte = 8'h0;
    case (lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    ld_data = 32'h0;
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      OP_LW:   ld_data = mem_rdata;
      default: ld_data = 32'h0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    lo_d          = lo_q;
    ld_we_d       = ld_we_q;
    ld_waddr_d    = ld_waddr_q;
    flush_d       = flush_q;
    reg_waddr_nxt = reg_waddr_o;
    reg_wdata_nxt = reg_wdata_o;
    we_nxt        = 1'b0;          // we_o is a one-cycle strobe
    misalign_nxt  = 1'b0;          // so is misalign_o
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr_o;
    mem_wmask_nxt = mem_wmask;
    mem_wdata_nxt = mem_wdata_o;

    case (state_q)
      IDLE: begin
        if (valid_i && !flush) begin
          if (misaligned_i) begin
            misalign_nxt = 1'b1;
          end else if (is_load_i || is_store_i) begin
            state_d       = BUSY;
            op_d          = mem_op_i;
            lo_d          = reg_wdata_i[1:0];
            ld_we_d       = we_i;
            ld_waddr_d    = reg_waddr_i;
            flush_d       = 1'b0;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = is_store_i;
            mem_addr_nxt  = {reg_wdata_i[31:2], 2'b00};
            mem_wmask_nxt = st_mask;
            mem_wdata_nxt = st_data;
          end else begin
            we_nxt        = we_i;
            reg_waddr_nxt = reg_waddr_i;
            reg_wdata_nxt = reg_wdata_i;
          end
        end
      end

      BUSY: begin
        // A flush cannot cancel a bus cycle already in flight; it only
        // suppresses the register write when the cycle completes.
        if (flush) flush_d = 1'b1;
        if (mem_ack) begin
          state_d       = IDLE;
          mem_req_nxt   = 1'b0;
          mem_we_nxt    = 1'b0;
          mem_wmask_nxt = 4'b0000;
          reg_waddr_nxt = ld_waddr_q;
          reg_wdata_nxt = ld_data;
          we_nxt        = is_load_q && ld_we_q && !flush_q && !flush;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 4'd0;
      lo_q        <= 2'd0;
      ld_we_q     <= 1'b0;
      ld_waddr_q  <= 5'd0;
      flush_q     <= 1'b0;
      reg_waddr_o <= 5'd0;
      we_o        <= 1'b0;
      reg_wdata_o <= 32'h0;
      misalign_o  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wmask   <= 4'b0000;
      mem_wdata_o <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      ld_we_q     <= ld_we_d;
      ld_waddr_q  <= ld_waddr_d;
      flush_q     <= flush_d;
      reg_waddr_o <= reg_waddr_nxt;
      we_o        <= we_nxt;
      reg_wdata_o <= reg_wdata_nxt;
      misalign_o  <= misalign_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr_o  <= mem_addr_nxt;
      mem_wmask   <= mem_wmask_nxt;
      mem_wdata_o <= mem_wdata_nxt;
    end
  end

endmodule
